// File: rtl/uart_pkg.sv
// Shared types and constants for the host-link UART receive path.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic                  pop_i,
    output logic [WIDTH-1:0]      rdata_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  full_o,
    output logic                  empty_o
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_WIDTH:0]   count_q;
    logic                  do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 serial deserializer feeding a receive FIFO popped by the core.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int ADDR_WIDTH    = 10,
    parameter int HALF_INTERVAL = 650,
    parameter int INTERVAL      = 1302
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic [ADDR_WIDTH:0]  rx_count,
    output logic                 overrun,
    output logic                 frame_error
);
    localparam int CNT_W = $clog2(INTERVAL);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_INTERVAL - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(INTERVAL - 1);
    localparam logic [BIT_W-1:0] IDX_LAST  = BIT_W'(DATA_BITS - 1);

    logic                 sync_q, rx_s_q;
    rx_state_t            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 overrun_q, overrun_d;
    logic                 ferr_q, ferr_d;
    logic                 push, pop, fifo_full, fifo_empty;

    // Line idles high, so the synchronizer resets to 1 to avoid a false start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= 1'b1;
            rx_s_q <= 1'b1;
        end else begin
            sync_q <= uart_rx;
            rx_s_q <= sync_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            overrun_q <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            overrun_q <= overrun_d;
            ferr_q    <= ferr_d;
        end
    end

    assign pop = rx_ready && !fifo_empty;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        idx_d     = idx_q;
        shift_d   = shift_q;
        overrun_d = 1'b0;
        ferr_d    = 1'b0;
        push      = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) state_d = START;
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        state_d = IDLE;
                        if (fifo_full && !pop) overrun_d = 1'b1;
                        else                   push      = 1'b1;
                    end else begin
                        state_d = BREAK;
                        ferr_d  = 1'b1;
                    end
                end
            end
            BREAK: begin
                cnt_d = '0;
                if (rx_s_q) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    sync_fifo #(
        .WIDTH      (DATA_BITS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (push),
        .wdata_i (shift_q),
        .pop_i   (rx_ready),
        .rdata_o (rx_data),
        .count_o (rx_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign rx_valid    = !fifo_empty;
    assign overrun     = overrun_q;
    assign frame_error = ferr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Randomized bench for uart_receiver against a queue-based reference model.
module tb_uart_receiver;

    localparam int HALF     = 8;
    localparam int INTV     = 16;
    localparam int AW       = 2;
    localparam int DEPTH    = 4;
    // Line fall -> stop decision edge: 2 sync flops, IDLE->START, then the stop sample point.
    localparam int STOP_OFS = 3 + HALF + 9 * INTV;

    logic          clk      = 1'b0;
    logic          reset    = 1'b0;
    logic          uart_rx  = 1'b1;
    logic          rx_ready = 1'b0;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [AW:0]   rx_count;
    logic          overrun;
    logic          frame_error;

    typedef struct {
        int         edge_c;
        bit         good;
        logic [7:0] data;
    } evt_t;

    evt_t       evq[$];
    logic [7:0] model_q[$];
    logic [7:0] popped_q[$];
    bit         exp_ovr = 1'b0;
    bit         exp_ferr = 1'b0;
    bit         m_pop, m_push;
    evt_t       m_e;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_pass = 0;
    int         n_ovr = 0;
    int         n_ferr = 0;

    uart_receiver #(
        .ADDR_WIDTH    (AW),
        .HALF_INTERVAL (HALF),
        .INTERVAL      (INTV)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .uart_rx     (uart_rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_count    (rx_count),
        .overrun     (overrun),
        .frame_error (frame_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    endtask

    function automatic logic [63:0] pack_popped();
        logic [63:0] v = '0;
        foreach (popped_q[i]) v = {v[55:0], popped_q[i]};
        return v;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Must be called 1 time unit after a rising edge.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int hold_low);
        evt_t e;
        e.edge_c = cyc + STOP_OFS;
        e.good   = stop_ok;
        e.data   = b;
        evq.push_back(e);
        uart_rx = 1'b0;
        wait_cyc(INTV);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            wait_cyc(INTV);
        end
        uart_rx = stop_ok;
        wait_cyc(INTV);
        if (!stop_ok) begin
            if (hold_low > 0) wait_cyc(hold_low);
            uart_rx = 1'b1;
        end
    endtask

    // Mid-cycle: compare outputs with the model, then advance the model to the next edge.
    always @(negedge clk) begin
        if (!reset) begin
            model_q.delete();
            exp_ovr  = 1'b0;
            exp_ferr = 1'b0;
        end
        check("valid", 64'(rx_valid), 64'(model_q.size() > 0));
        check("count", 64'(rx_count), 64'(model_q.size()));
        if (model_q.size() > 0) check("data", 64'(rx_data), 64'(model_q[0]));
        check("overrun", 64'(overrun), 64'(exp_ovr));
        check("frame_error", 64'(frame_error), 64'(exp_ferr));
        if (overrun) n_ovr++;
        if (frame_error) n_ferr++;
        if (rx_valid && rx_ready) popped_q.push_back(rx_data);

        exp_ovr  = 1'b0;
        exp_ferr = 1'b0;
        m_push   = 1'b0;
        if (reset) begin
            m_pop = (model_q.size() > 0) && rx_ready;
            if (evq.size() > 0 && evq[0].edge_c == cyc + 1) begin
                m_e = evq.pop_front();
                if (!m_e.good)                              exp_ferr = 1'b1;
                else if (model_q.size() < DEPTH || m_pop)   m_push   = 1'b1;
                else                                        exp_ovr  = 1'b1;
            end
            if (m_pop)  void'(model_q.pop_front());
            if (m_push) model_q.push_back(m_e.data);
        end
    end

    initial begin
        wait_cyc(3);
        check("rst_valid", 64'(rx_valid), 64'd0);
        check("rst_count", 64'(rx_count), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        check("rst_ferr", 64'(frame_error), 64'd0);
        reset = 1'b1;
        wait_cyc(3);

        // Single frame, consumer always ready
        rx_ready = 1'b1;
        send_frame(8'h55, 1'b1, 0);
        wait_cyc(5);
        check("t1_npop", 64'(popped_q.size()), 64'd1);
        check("t1_byte", pack_popped(), 64'h55);
        check("t1_count", 64'(rx_count), 64'd0);
        popped_q.delete();

        // Short low glitch on an idle line
        uart_rx = 1'b0;
        wait_cyc(4);
        uart_rx = 1'b1;
        wait_cyc(40);
        check("t2_pulses", 64'(n_ovr + n_ferr), 64'd0);
        check("t2_count", 64'(rx_count), 64'd0);

        // Bad stop bit followed by a held-low break, then a clean frame
        n_ferr = 0;
        send_frame(8'hA3, 1'b0, 100);
        wait_cyc(10);
        check("t3_ferr_pulses", 64'(n_ferr), 64'd1);
        check("t3_count", 64'(rx_count), 64'd0);
        send_frame(8'h3C, 1'b1, 0);
        wait_cyc(5);
        check("t3_npop", 64'(popped_q.size()), 64'd1);
        check("t3_byte", pack_popped(), 64'h3C);
        popped_q.delete();

        // Fill with consumer stalled, fifth frame overruns
        rx_ready = 1'b0;
        n_ovr = 0;
        for (int k = 1; k <= 4; k++) begin
            send_frame(8'(k), 1'b1, 0);
            wait_cyc(2);
        end
        check("t4_count", 64'(rx_count), 64'd4);
        check("t4_head", 64'(rx_data), 64'h01);
        send_frame(8'h05, 1'b1, 0);
        wait_cyc(4);
        check("t4_ovr_pulses", 64'(n_ovr), 64'd1);
        check("t4_count_after", 64'(rx_count), 64'd4);

        // Full FIFO, pop coincides with the stop sample of 0x77
        fork
            send_frame(8'h77, 1'b1, 0);
            begin
                wait_cyc(STOP_OFS - 1);
                rx_ready = 1'b1;
                wait_cyc(1);
                rx_ready = 1'b0;
                check("t5_count_full", 64'(rx_count), 64'd4);
            end
        join
        wait_cyc(5);
        rx_ready = 1'b1;
        wait_cyc(8);
        rx_ready = 1'b0;
        check("t5_npop", 64'(popped_q.size()), 64'd5);
        check("t5_order", pack_popped(), 64'h01_02_03_04_77);
        check("t5_count", 64'(rx_count), 64'd0);
        check("t5_ovr_total", 64'(n_ovr), 64'd1);
        popped_q.delete();

        // Reset in the middle of data bit 3, with one byte already queued
        send_frame(8'h99, 1'b1, 0);
        wait_cyc(4);
        check("t6_pre_count", 64'(rx_count), 64'd1);
        uart_rx = 1'b0;
        wait_cyc(INTV);
        for (int i = 0; i < 3; i++) begin
            uart_rx = i[0];
            wait_cyc(INTV);
        end
        uart_rx = 1'b1;
        wait_cyc(6);
        reset = 1'b0;
        evq.delete();
        #1;
        check("t6_valid", 64'(rx_valid), 64'd0);
        check("t6_count", 64'(rx_count), 64'd0);
        check("t6_overrun", 64'(overrun), 64'd0);
        check("t6_ferr", 64'(frame_error), 64'd0);
        wait_cyc(4);
        reset = 1'b1;
        wait_cyc(4);
        rx_ready = 1'b1;
        send_frame(8'hC5, 1'b1, 0);
        wait_cyc(5);
        check("t6_npop", 64'(popped_q.size()), 64'd1);
        check("t6_byte", pack_popped(), 64'hC5);
        popped_q.delete();

        // Random frames, random stop validity, random consumer stalls
        for (int f = 0; f < 30; f++) begin
            logic [7:0] b;
            bit         ok;
            int         hold;
            b    = 8'($urandom_range(0, 255));
            ok   = ($urandom_range(0, 4) != 0);
            hold = $urandom_range(0, 30);
            fork
                send_frame(b, ok, hold);
                begin
                    repeat (STOP_OFS + 6) begin
                        rx_ready = 1'($urandom_range(0, 1));
                        wait_cyc(1);
                    end
                end
            join
            wait_cyc($urandom_range(4, 20));
        end

        rx_ready = 1'b1;
        wait_cyc(20);
        check("final_count", 64'(rx_count), 64'd0);
        check("final_valid", 64'(rx_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Receive side of the host serial link. Deserializes 8N1 frames from the board-registered `uart_rx` line and queues received bytes in an on-chip FIFO. The core pops bytes with a valid/ready handshake. Bit timing is fixed by parameters: 150 MHz clock, 115200 baud.

## Interface
- `ADDR_WIDTH`, 10: FIFO depth is 2**ADDR_WIDTH entries.
- `HALF_INTERVAL`, 650: clocks from detected start edge to the mid-start-bit sample.
- `INTERVAL`, 1302: clocks per bit between subsequent samples.
- `clk` in 1: single clock; all logic is on posedge.
- `reset` in 1: asynchronous, active-low. Asserting it clears all state immediately.
- `uart_rx` in 1: serial line, idle high. Registered once at board level; asynchronous to this block's bit timing.
- `rx_data` out 8: byte at FIFO head.
- `rx_valid` out 1: FIFO non-empty.
- `rx_ready` in 1: consumer pops the head when `rx_valid && rx_ready`.
- `rx_count` out ADDR_WIDTH+1: current FIFO occupancy.
- `overrun` out 1: one-cycle pulse when a good byte is dropped because the FIFO is full.
- `frame_error` out 1: one-cycle pulse when the stop bit samples 0.

## Operation
- The line passes through a 2-flop synchronizer (both flops reset to 1) to produce `rx_s`.
- A bit counter is ADDR-independent, width $clog2(INTERVAL), and resets to 0 on every state entry.
- FSM states: IDLE, START, DATA, STOP, BREAK. Reset state is IDLE.
  - IDLE: when `rx_s`==0, go to START.
  - START: at counter==HALF_INTERVAL-1, sample `rx_s`. 0 goes to DATA with bit index 0; 1 is treated as a glitch and goes to IDLE.
  - DATA: at counter==INTERVAL-1, sample `rx_s` into the shift register, LSB first (shift right, new bit into bit 7). After bit index 7, go to STOP.
  - STOP: at counter==INTERVAL-1, sample `rx_s`.
    - 1: push the byte, or pulse `overrun` if the FIFO is full and no pop occurs that cycle. Go to IDLE.
    - 0: pulse `frame_error`, discard the byte, go to BREAK.
  - BREAK: wait for `rx_s`==1, then go to IDLE. A held-low line yields exactly one `frame_error`.
- FIFO behaviour:
  - First-word-fall-through: `rx_data` = mem[rd_ptr].
  - Pointers are ADDR_WIDTH bits and wrap modulo depth.
  - `rx_count` increments on push only, decrements on pop only, and is unchanged on a simultaneous push and pop.
  - Push while full and pop in the same cycle: the push is accepted and count stays at depth.
  - Pop while empty is ignored.

## Timing
- Reset values:
  - `rx_valid`=0, `rx_count`=0, `overrun`=0, `frame_error`=0.
  - `rx_data` is don't-care while `rx_valid`=0.
  - Pointers are 0 and the FSM is in IDLE.
- Start detection: a falling edge on `uart_rx` is seen in IDLE 2 cycles later. START is entered the following cycle.
- Sample points, relative to START entry:
  - Start bit: HALF_INTERVAL-1.
  - Data bit k: HALF_INTERVAL + (k+1)*INTERVAL - 1.
  - Stop bit: HALF_INTERVAL + 9*INTERVAL - 1.
- Push happens on the stop-sample edge. `rx_valid` and `rx_count` update on the next cycle.
- `overrun` and `frame_error` are high for exactly the one cycle after the stop sample.
- Pop takes effect at the edge where `rx_valid && rx_ready`. The next head appears the following cycle.
- Reset asserted mid-frame aborts the frame with no push and no pulse.
- Reset flushes the FIFO.

## Structure
- Package `uart_pkg` holds:
  - `typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t`
  - `localparam` DATA_BITS=8
- One sub-module, `sync_fifo` (parameters WIDTH, ADDR_WIDTH), contains the storage, pointers, count and FWFT read.
- The deserializer FSM lives in `uart_receiver`.

## Test plan
Bench parameters: HALF_INTERVAL=8, INTERVAL=16, ADDR_WIDTH=2.
1. Send frame 0x55 with `rx_ready`=1.
   - `rx_valid` rises one cycle after the stop sample with `rx_data`=0x55.
   - Popped immediately; `rx_count` returns to 0.
2. Drive a low glitch of 4 cycles on an idle line.
   - No push, no pulses, FSM back in IDLE.
3. Send 0xA3 with the stop bit driven 0 and then held low for 100 cycles.
   - Exactly one `frame_error` pulse, `rx_count`=0.
   - A following 0x3C frame is received correctly.
4. With `rx_ready`=0, send 0x01..0x05.
   - `rx_count`=4 and `rx_data`=0x01.
   - The 5th frame gives one `overrun` pulse.
   - Draining yields 0x01..0x04 in order.
5. FIFO full, `rx_ready`=1 on the cycle of a 0x77 stop sample.
   - Pop and push both occur; `rx_count` stays 4.
   - Drain order: 0x02, 0x03, 0x04, 0x77.
6. Drop `reset` to 0 during data bit 3 of a frame.
   - All outputs 0 immediately, no push.
   - After release, 0xC5 is received correctly.
